// File: rtl/sdram_sequencer_pkg.sv
// Shared state encodings and default timing constants for the SDRAM stream
// path. The command controller decodes the same encodings.
package sdram_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT          = 3'd0,
    ST_CONTROL       = 3'd1,
    ST_WRITE         = 3'd2,
    ST_READ          = 3'd3,
    ST_REFRESH       = 3'd4,
    ST_FORCE_REFRESH = 3'd5,
    ST_POWERUP       = 3'd6
  } sdram_state_t;

  localparam int WR_LEN_DEF   = 518;
  localparam int RD_LEN_DEF   = 520;
  localparam int REF_LEN_DEF  = 8;
  localparam int FREF_LEN_DEF = 9;
  localparam logic [9:0] UNI_TIME_MAX = 10'h3FF;

  // Saturating increment for the per-state cycle counter.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == UNI_TIME_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sdram_sequencer_refresh_scheduler.sv
// Refresh debt tracker: a REFI interval timer that adds one owed refresh per
// expiry, and controller AUTO_REFRESH pulses that pay one back. The debt
// saturates at 15 and a lost increment latches refresh_overrun.
module refresh_scheduler #(
  parameter int REFI = 780
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       incr_refs_cnt,
  output logic [3:0] refs_pending,
  output logic       refresh_overrun
);

  localparam int TW = (REFI > 1) ? $clog2(REFI) : 1;

  logic [TW-1:0] timer;
  logic          expire;

  assign expire = enable && (timer == TW'(REFI - 1));

  // Interval timer; held at zero until init has completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     timer <= '0;
    else if (!enable || expire)  timer <= '0;
    else                         timer <= timer + 1'b1;
  end

  // Debt counter: expiry and a paid refresh in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refs_pending    <= 4'd0;
      refresh_overrun <= 1'b0;
    end else if (enable) begin
      case ({expire, incr_refs_cnt})
        2'b10: begin
          if (refs_pending == 4'hF) refresh_overrun <= 1'b1;
          else                      refs_pending    <= refs_pending + 4'd1;
        end
        2'b01: if (refs_pending != 4'd0) refs_pending <= refs_pending - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_sequencer.sv
// Top-level SDRAM scheduler: chooses power-up, init, write/read bursts and
// refreshes, and presents the current state plus cycles-in-state to the
// command controller.
module sdram_sequencer
  import sdram_sequencer_pkg::*;
#(
  parameter int PWR_WAIT   = 20000,
  parameter int REFI       = 780,
  parameter int FORCE_DEBT = 4,
  parameter int WR_LEN     = WR_LEN_DEF,
  parameter int RD_LEN     = RD_LEN_DEF,
  parameter int REF_LEN    = REF_LEN_DEF,
  parameter int FREF_LEN   = FREF_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdram_rfo,
  input  logic       incr_refs_cnt,
  input  logic       sdram_full,
  input  logic       sdram_empty,
  input  logic       wr_burst_ready,
  input  logic       rd_space_ready,
  output logic [2:0] sdram_state,
  output logic [9:0] uni_time,
  output logic [3:0] refs_pending,
  output logic       refresh_overrun
);

  localparam int PW = (PWR_WAIT > 1) ? $clog2(PWR_WAIT + 1) : 1;

  sdram_state_t  state, state_nxt;
  logic          last_wr, last_wr_nxt;
  logic [PW-1:0] pwr_cnt;
  logic          wr_ok, rd_ok, pwr_done, sched_en;

  assign wr_ok    = wr_burst_ready & ~sdram_full;
  assign rd_ok    = rd_space_ready & ~sdram_empty;
  assign pwr_done = (pwr_cnt == PW'(PWR_WAIT - 1));
  // Refresh debt only accrues once init has finished.
  assign sched_en = (state != ST_POWERUP) && (state != ST_INIT);

  assign sdram_state = state;

  refresh_scheduler #(.REFI(REFI)) u_refresh_scheduler (
    .clk            (clk),
    .rst            (rst),
    .enable         (sched_en),
    .incr_refs_cnt  (incr_refs_cnt),
    .refs_pending   (refs_pending),
    .refresh_overrun(refresh_overrun)
  );

  // Next-state decision; bursts alternate when both directions are eligible.
  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    case (state)
      ST_POWERUP: if (pwr_done) state_nxt = ST_INIT;
      ST_INIT:    if (sdram_rfo) state_nxt = ST_CONTROL;
      ST_CONTROL: begin
        if (refs_pending >= 4'(FORCE_DEBT)) begin
          state_nxt = ST_FORCE_REFRESH;
        end else if (wr_ok && (!rd_ok || !last_wr)) begin
          state_nxt   = ST_WRITE;
          last_wr_nxt = 1'b1;
        end else if (rd_ok) begin
          state_nxt   = ST_READ;
          last_wr_nxt = 1'b0;
        end else if (refs_pending != 4'd0) begin
          state_nxt = ST_REFRESH;
        end
      end
      ST_WRITE:         if (uni_time == 10'(WR_LEN - 1))   state_nxt = ST_CONTROL;
      ST_READ:          if (uni_time == 10'(RD_LEN - 1))   state_nxt = ST_CONTROL;
      ST_REFRESH:       if (uni_time == 10'(REF_LEN - 1))  state_nxt = ST_CONTROL;
      ST_FORCE_REFRESH: if (uni_time == 10'(FREF_LEN - 1)) state_nxt = ST_CONTROL;
      default:          state_nxt = ST_POWERUP;
    endcase
  end

  // State and burst-direction history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_POWERUP;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Cycles since state entry: zero on entry and throughout power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          uni_time <= 10'd0;
    else if (state_nxt != state || state == ST_POWERUP) uni_time <= 10'd0;
    else                                              uni_time <= sat_inc10(uni_time);
  end

  // Power-up wait counter; stops once the wait has elapsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pwr_cnt <= '0;
    else if (state == ST_POWERUP && !pwr_done) pwr_cnt <= pwr_cnt + 1'b1;
  end

endmodule

// File: tb/tb_sdram_sequencer.sv
// Bench for sdram_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// behavioural model of the scheduling rules.
module tb_sdram_sequencer;

  localparam int PWR_WAIT = 10;
  localparam int REFI     = 780;
  localparam int FDEBT    = 4;
  localparam int WRL = 518, RDL = 520, REFL = 8, FREFL = 9;

  logic clk = 1'b0;
  logic rst, sdram_rfo, incr_refs_cnt, sdram_full, sdram_empty;
  logic wr_burst_ready, rd_space_ready;
  logic [2:0] sdram_state;
  logic [9:0] uni_time;
  logic [3:0] refs_pending;
  logic       refresh_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_sequencer #(
    .PWR_WAIT(PWR_WAIT), .REFI(REFI), .FORCE_DEBT(FDEBT),
    .WR_LEN(WRL), .RD_LEN(RDL), .REF_LEN(REFL), .FREF_LEN(FREFL)
  ) dut (
    .clk(clk), .rst(rst), .sdram_rfo(sdram_rfo), .incr_refs_cnt(incr_refs_cnt),
    .sdram_full(sdram_full), .sdram_empty(sdram_empty),
    .wr_burst_ready(wr_burst_ready), .rd_space_ready(rd_space_ready),
    .sdram_state(sdram_state), .uni_time(uni_time),
    .refs_pending(refs_pending), .refresh_overrun(refresh_overrun)
  );

  // ---------------- behavioural model ----------------
  // m_run counts cycles since init completed; a refresh falls due every
  // REFI-th such cycle. Debt is kept as a plain integer and clamped.
  int m_state = 6, m_time = 0, m_pend = 0, m_ovr = 0, m_run = 0, m_pu = 0;
  int m_last_wr = 0;
  int nst, np;
  bit active, due, wr_e, rd_e;

  function automatic int len_of(input int s);
    case (s)
      2: return WRL;
      3: return RDL;
      4: return REFL;
      default: return FREFL;
    endcase
  endfunction

  // Model advances on each clock edge; reset is immediate like the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 6; m_time = 0; m_pend = 0; m_ovr = 0;
      m_run = 0; m_pu = 0; m_last_wr = 0;
    end else begin
      active = (m_state != 6) && (m_state != 0);
      due    = active && (((m_run + 1) % REFI) == 0);
      wr_e   = wr_burst_ready && !sdram_full;
      rd_e   = rd_space_ready && !sdram_empty;
      nst    = m_state;
      case (m_state)
        6: if (m_pu + 1 >= PWR_WAIT) nst = 0;
        0: if (sdram_rfo) nst = 1;
        1: begin
          if (m_pend >= FDEBT) nst = 5;
          else if (wr_e && rd_e) begin
            nst = (m_last_wr != 0) ? 3 : 2;
            m_last_wr = (nst == 2) ? 1 : 0;
          end
          else if (wr_e) begin nst = 2; m_last_wr = 1; end
          else if (rd_e) begin nst = 3; m_last_wr = 0; end
          else if (m_pend > 0) nst = 4;
        end
        default: if (m_time + 1 == len_of(m_state)) nst = 1;
      endcase
      if (active) begin
        np = m_pend + int'(due) - int'(incr_refs_cnt);
        if (np > 15) begin np = 15; m_ovr = 1; end
        if (np < 0) np = 0;
        m_pend = np;
        m_run++;
      end
      m_pu   = (m_state == 6) ? m_pu + 1 : 0;
      m_time = (nst != m_state || nst == 6) ? 0 : ((m_time < 1023) ? m_time + 1 : 1023);
      m_state = nst;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    checks++;
    if (int'(sdram_state) != m_state || int'(uni_time) != m_time ||
        int'(refs_pending) != m_pend || int'(refresh_overrun) != m_ovr) begin
      errors++;
      $display("FAIL model t=%0t state=%0d/%0d time=%0d/%0d pend=%0d/%0d ovr=%0d/%0d (got/want)",
               $time, sdram_state, m_state, uni_time, m_time,
               refs_pending, m_pend, refresh_overrun, m_ovr);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Count cycles spent in state s starting from its first cycle.
  task automatic measure(input int s, input int exp_len, input string name);
    int n = 0;
    while (int'(sdram_state) == s && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp_len);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(sdram_state) != s && n < budget) begin
      n++;
      @(negedge clk);
    end
    chk(name, int'(sdram_state), s);
  endtask

  initial begin
    int n;
    rst = 1'b1; sdram_rfo = 1'b0; incr_refs_cnt = 1'b0; sdram_full = 1'b0;
    sdram_empty = 1'b1; wr_burst_ready = 1'b0; rd_space_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", sdram_state, 6);
    chk("reset_time", uni_time, 0);
    chk("reset_pend", refs_pending, 0);
    chk("reset_ovr", refresh_overrun, 0);

    // Power-up length, then init until rfo at uni_time 15.
    rst = 1'b0;
    n = 0;
    while (sdram_state == 3'd6 && n < 100) begin @(negedge clk); n++; end
    chk("powerup_len", n, PWR_WAIT);
    chk("init_entry", sdram_state, 0);
    n = 0;
    while (uni_time != 10'd15 && n < 100) begin @(negedge clk); n++; end
    sdram_rfo = 1'b1;
    @(negedge clk);
    chk("control_entry", sdram_state, 1);
    chk("control_time", uni_time, 0);

    // Both directions eligible: write, read, write.
    wr_burst_ready = 1'b1; rd_space_ready = 1'b1; sdram_empty = 1'b0;
    @(negedge clk);
    chk("first_write", sdram_state, 2);
    measure(2, WRL, "write_len");
    chk("after_write", sdram_state, 1);
    @(negedge clk);
    chk("then_read", sdram_state, 3);
    measure(3, RDL, "read_len");
    chk("after_read", sdram_state, 1);
    @(negedge clk);
    chk("alternate_write", sdram_state, 2);

    // Write blocked by full ring, read idle: drain debt, wait for one owed
    // refresh, then pay it during REFRESH.
    sdram_full = 1'b1; rd_space_ready = 1'b0;
    n = 0;
    while (m_pend > 0 && n < 50) begin incr_refs_cnt = 1'b1; @(negedge clk); n++; end
    incr_refs_cnt = 1'b0;
    wait_state(4, 3000, "refresh_entry");
    chk("refresh_pend_in", refs_pending, 1);
    incr_refs_cnt = 1'b1;
    @(negedge clk);
    incr_refs_cnt = 1'b0;
    chk("refresh_paid", refs_pending, 0);
    measure(4, REFL - 1, "refresh_len");

    // Continuous writes with no refreshes paid: debt forces FORCE_REFRESH.
    sdram_full = 1'b0;
    wait_state(5, 8000, "force_entry");
    chk("force_debt", int'(refs_pending >= 4'd4), 1);
    chk("force_wr_still_ok", int'(wr_burst_ready && !sdram_full), 1);
    measure(5, FREFL, "force_len");

    // Bring debt to 2, then pay a refresh on the very cycle one falls due.
    n = 0;
    while (m_pend > 2 && n < 50) begin incr_refs_cnt = 1'b1; @(negedge clk); n++; end
    incr_refs_cnt = 1'b0;
    n = 0;
    while (((m_run + 1) % REFI) != 0 && n < REFI + 10) begin @(negedge clk); n++; end
    incr_refs_cnt = 1'b1;
    @(negedge clk);
    incr_refs_cnt = 1'b0;
    chk("same_cycle_hold", refs_pending, 2);

    // Let debt saturate, then one more expiry sets overrun.
    n = 0;
    while (refs_pending != 4'd15 && n < 20000) begin @(negedge clk); n++; end
    chk("saturated", refs_pending, 15);
    chk("no_overrun_yet", refresh_overrun, 0);
    repeat (REFI + 2) @(negedge clk);
    chk("sat_hold", refs_pending, 15);
    chk("overrun_set", refresh_overrun, 1);

    // Reset in the middle of a write burst.
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!(sdram_state == 3'd2 && uni_time == 10'd300) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("midburst_reached", uni_time, 300);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", sdram_state, 6);
    chk("midrst_time", uni_time, 0);
    chk("midrst_pend", refs_pending, 0);
    chk("midrst_ovr", refresh_overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      sdram_rfo     = ($urandom_range(0, 7) != 0);
      incr_refs_cnt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) begin
        wr_burst_ready = $urandom_range(0, 1) != 0;
        rd_space_ready = $urandom_range(0, 1) != 0;
        sdram_full     = $urandom_range(0, 3) == 0;
        sdram_empty    = $urandom_range(0, 3) == 0;
      end
    end
    incr_refs_cnt = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
